// File: rtl/regfile_mp.sv
// Parametrised multi-read-port register file with post-reset clear sweep and pending scoreboard.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle write data/pending onto the read ports.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clock__i,
  input  logic                     reset__i,
  output logic                     Ready__o,
  input  logic                     RegWrite__i,
  input  logic [ADDR_W-1:0]        AddrRd__i,
  input  logic [DATA_W-1:0]        DataRd__i,
  input  logic                     Reserve__i,
  input  logic [ADDR_W-1:0]        AddrRes__i,
  input  logic [NUM_RD*ADDR_W-1:0] AddrR__i,
  output logic [NUM_RD*DATA_W-1:0] DataR__o,
  output logic [NUM_RD-1:0]        Pending__o
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clrCnt_q, clrCnt_d;
  logic [DEPTH-1:0]  pending_q, pending_d;
  logic [DATA_W-1:0] regs_q [DEPTH];

  logic wrEn, resEn;

  // Register 0 is silently immune to writes and reserves when hardwired to zero.
  assign wrEn  = (state_q == RUN) && RegWrite__i &&
                 !((ZERO_REG != 0) && (AddrRd__i == '0));
  assign resEn = (state_q == RUN) && Reserve__i &&
                 !((ZERO_REG != 0) && (AddrRes__i == '0));

  always_comb begin
    state_d   = state_q;
    clrCnt_d  = clrCnt_q;
    pending_d = pending_q;
    case (state_q)
      CLEAR: begin
        clrCnt_d = clrCnt_q + 1'b1;
        if (clrCnt_q == LAST) state_d = RUN;
      end
      RUN: begin
        if (wrEn)  pending_d[AddrRd__i]  = 1'b0;
        // A reserve issued alongside a write belongs to a newer producer, so it wins.
        if (resEn) pending_d[AddrRes__i] = 1'b1;
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clock__i) begin
    if (reset__i) begin
      state_q   <= CLEAR;
      clrCnt_q  <= '0;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      clrCnt_q  <= clrCnt_d;
      pending_q <= pending_d;
    end
  end

  always_ff @(posedge clock__i) begin
    if (!reset__i) begin
      if (state_q == CLEAR) regs_q[clrCnt_q] <= '0;
      else if (wrEn)        regs_q[AddrRd__i] <= DataRd__i;
    end
  end

  assign Ready__o = (state_q == RUN);

  for (genvar k = 0; k < NUM_RD; k++) begin : gRead
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] rdData;
    logic              rdPend;

    assign addr = AddrR__i[k*ADDR_W +: ADDR_W];

    always_comb begin
      rdData = regs_q[addr];
      rdPend = pending_q[addr];
`ifdef REGFILE_BYPASS_EN
      if (wrEn && (AddrRd__i == addr)) begin
        rdData = DataRd__i;
        rdPend = resEn && (AddrRes__i == addr);
      end
`endif
      // Outputs are forced quiet during the sweep since array contents are not yet defined.
      if ((state_q == CLEAR) || ((ZERO_REG != 0) && (addr == '0))) begin
        rdData = '0;
        rdPend = 1'b0;
      end
    end

    assign DataR__o[k*DATA_W +: DATA_W] = rdData;
    assign Pending__o[k]                = rdPend;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Randomised self-checking bench for regfile_mp against an array-based behavioural model.
module tb_regfile_mp;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ready;
  logic        regWrite = 1'b0;
  logic [4:0]  addrRd = '0;
  logic [31:0] dataRd = '0;
  logic        reserve = 1'b0;
  logic [4:0]  addrRes = '0;
  logic [9:0]  addrR = '0;
  logic [63:0] dataR;
  logic [1:0]  pendR;

  int compared = 0;
  int mismatched = 0;

  // Behavioural model: register contents, pending flags, and sweep progress as a plain count.
  logic [31:0] mReg [32];
  bit          mPend [32];
  bit          mReady = 1'b0;
  int          mSweep = 0;

  regfile_mp dut (
    .clock__i    (clk),
    .reset__i    (reset),
    .Ready__o    (ready),
    .RegWrite__i (regWrite),
    .AddrRd__i   (addrRd),
    .DataRd__i   (dataRd),
    .Reserve__i  (reserve),
    .AddrRes__i  (addrRes),
    .AddrR__i    (addrR),
    .DataR__o    (dataR),
    .Pending__o  (pendR)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] modelData(input logic [4:0] a);
    if (!mReady || a == 5'd0) return 32'h0;
    if (BYPASS && regWrite && addrRd == a) return dataRd;
    return mReg[a];
  endfunction

  function automatic logic modelPend(input logic [4:0] a);
    if (!mReady || a == 5'd0) return 1'b0;
    if (BYPASS && regWrite && addrRd == a) return reserve && (addrRes == a);
    return mPend[a];
  endfunction

  // Advance the model with the inputs present at this edge, then move just past the edge.
  task automatic tick();
    if (reset) begin
      mReady = 1'b0;
      mSweep = 0;
      for (int i = 0; i < 32; i++) mPend[i] = 1'b0;
    end else if (!mReady) begin
      mReg[mSweep] = 32'h0;
      mSweep++;
      if (mSweep == 32) begin
        mReady = 1'b1;
        mSweep = 0;
      end
    end else begin
      if (regWrite && addrRd != 5'd0) begin
        mReg[addrRd]  = dataRd;
        mPend[addrRd] = 1'b0;
      end
      if (reserve && addrRes != 5'd0) mPend[addrRes] = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic applyIdle();
    regWrite = 1'b0;
    reserve  = 1'b0;
  endtask

  task automatic test_reset();
    int edges;
    reset = 1'b1;
    applyIdle();
    repeat (3) tick();
    addrR = {5'd5, 5'd0};
    #1;
    compared++;
    if (ready !== 1'b0 || dataR !== 64'h0 || pendR !== 2'b00) begin
      mismatched++;
      $display("[TB] FAIL reset_state: ready=%b data=%h pend=%b, required ready=0 data=0 pend=00",
               ready, dataR, pendR);
    end
    reset = 1'b0;
    edges = 0;
    while (ready !== 1'b1 && edges < 100) begin
      tick();
      edges++;
    end
    compared++;
    if (edges != 32) begin
      mismatched++;
      $display("[TB] FAIL clear_latency: ready after %0d edges, required 32", edges);
    end
    for (int a = 0; a < 32; a++) begin
      addrR = {5'(31 - a), 5'(a)};
      #1;
      compared++;
      if (dataR !== 64'h0) begin
        mismatched++;
        $display("[TB] FAIL clear_contents: addr %0d data=%h, required 0", a, dataR);
      end
    end
  endtask

  task automatic test_write_read();
    regWrite = 1'b1; addrRd = 5'd5; dataRd = 32'hDEADBEEF;
    tick();
    applyIdle();
    addrR = {5'd5, 5'd5};
    #1;
    compared++;
    if (dataR !== {32'hDEADBEEF, 32'hDEADBEEF}) begin
      mismatched++;
      $display("[TB] FAIL write_read_r5: data=%h, required deadbeefdeadbeef", dataR);
    end
    regWrite = 1'b1; addrRd = 5'd0; dataRd = 32'h1234;
    tick();
    applyIdle();
    addrR = {5'd0, 5'd0};
    #1;
    compared++;
    if (dataR !== 64'h0 || pendR !== 2'b00) begin
      mismatched++;
      $display("[TB] FAIL zero_reg: data=%h pend=%b, required 0/00", dataR, pendR);
    end
  endtask

  task automatic test_scoreboard();
    addrR = {5'd7, 5'd7};
    reserve = 1'b1; addrRes = 5'd7;
    tick();
    applyIdle();
    #1;
    compared++;
    if (pendR !== 2'b11) begin
      mismatched++;
      $display("[TB] FAIL reserve_r7: pend=%b, required 11", pendR);
    end
    regWrite = 1'b1; addrRd = 5'd7; dataRd = 32'h55;
    tick();
    applyIdle();
    #1;
    compared++;
    if (pendR !== 2'b00 || dataR[31:0] !== 32'h55) begin
      mismatched++;
      $display("[TB] FAIL write_clears_pend: pend=%b data=%h, required 00/00000055",
               pendR, dataR[31:0]);
    end
    regWrite = 1'b1; addrRd = 5'd7; dataRd = 32'h66;
    reserve = 1'b1; addrRes = 5'd7;
    tick();
    applyIdle();
    #1;
    compared++;
    if (pendR !== 2'b11 || dataR[63:32] !== 32'h66) begin
      mismatched++;
      $display("[TB] FAIL reserve_beats_write: pend=%b data=%h, required 11/00000066",
               pendR, dataR[63:32]);
    end
  endtask

  task automatic test_bypass();
    logic [31:0] expect9;
    regWrite = 1'b1; addrRd = 5'd9; dataRd = 32'h11111111;
    tick();
    addrR = {5'd9, 5'd9};
    dataRd = 32'hA5A5A5A5;
    #1;
    expect9 = BYPASS ? 32'hA5A5A5A5 : 32'h11111111;
    compared++;
    if (dataR[31:0] !== expect9 || dataR[63:32] !== expect9) begin
      mismatched++;
      $display("[TB] FAIL bypass_same_cycle: data=%h, required %h on both ports", dataR, expect9);
    end
    tick();
    applyIdle();
    #1;
    compared++;
    if (dataR[31:0] !== 32'hA5A5A5A5) begin
      mismatched++;
      $display("[TB] FAIL bypass_next_cycle: data=%h, required a5a5a5a5", dataR[31:0]);
    end
  endtask

  task automatic test_reset_mid_clear();
    int edges;
    reserve = 1'b1; addrRes = 5'd12;
    tick();
    applyIdle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (10) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    edges = 0;
    while (ready !== 1'b1 && edges < 100) begin
      tick();
      edges++;
    end
    compared++;
    if (edges != 32) begin
      mismatched++;
      $display("[TB] FAIL mid_clear_restart: ready after %0d edges, required 32", edges);
    end
    addrR = {5'd12, 5'd7};
    #1;
    compared++;
    if (pendR !== 2'b00) begin
      mismatched++;
      $display("[TB] FAIL mid_clear_pending: pend=%b, required 00", pendR);
    end
  endtask

  task automatic test_write_in_clear();
    int edges;
    regWrite = 1'b1; addrRd = 5'd3; dataRd = 32'hCAFE0003;
    tick();
    applyIdle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (6) tick();
    regWrite = 1'b1; addrRd = 5'd3; dataRd = 32'hFF;
    tick();
    applyIdle();
    edges = 7;
    while (ready !== 1'b1 && edges < 100) begin
      tick();
      edges++;
    end
    addrR = {5'd3, 5'd3};
    #1;
    compared++;
    if (ready !== 1'b1 || dataR !== 64'h0) begin
      mismatched++;
      $display("[TB] FAIL write_ignored_in_clear: ready=%b data=%h, required 1/0", ready, dataR);
    end
  endtask

  task automatic test_random();
    logic [4:0] a;
    for (int n = 0; n < 400; n++) begin
      reset    = ($urandom_range(0, 79) == 0);
      regWrite = $urandom_range(0, 1);
      addrRd   = 5'($urandom_range(0, 15));
      dataRd   = $urandom;
      reserve  = ($urandom_range(0, 2) == 0);
      addrRes  = 5'($urandom_range(0, 15));
      addrR    = {5'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0) ? addrRd : 5'($urandom_range(0, 15))};
      #1;
      for (int k = 0; k < 2; k++) begin
        a = addrR[k*5 +: 5];
        compared++;
        if (dataR[k*32 +: 32] !== modelData(a) || pendR[k] !== modelPend(a)) begin
          mismatched++;
          $display("[TB] FAIL random_read: cyc %0d port %0d addr %0d data=%h pend=%b, required %h/%b",
                   n, k, a, dataR[k*32 +: 32], pendR[k], modelData(a), modelPend(a));
        end
      end
      compared++;
      if (ready !== mReady) begin
        mismatched++;
        $display("[TB] FAIL random_ready: cyc %0d ready=%b, required %b", n, ready, mReady);
      end
      tick();
    end
    reset = 1'b0;
    applyIdle();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      mReg[i]  = 32'h0;
      mPend[i] = 1'b0;
    end
    test_reset();
    test_write_read();
    test_scoreboard();
    test_bypass();
    test_reset_mid_clear();
    test_write_in_clear();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-read-port general-purpose register file for the MIPS core. It is the successor to the fixed 32x32 two-read-port file. It adds configurable width, depth and read-port count, a posedge write, and a hardware clear sequencer that zeroes every register after reset. It also carries a per-register pending scoreboard so decode can detect in-flight producers. It sits between decode (read and reserve) and writeback (write).

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth DEPTH = 2**ADDR_W
- NUM_RD, 2, number of combinational read ports (1..4)
- ZERO_REG, 1, 1 = register 0 hardwired to zero, never written, never pending

Ports:
- clock__i  in  1  single clock; all state updates on posedge
- reset__i  in  1  synchronous, active-high reset
- Ready__o  out  1  high once the clear sequence has completed
- RegWrite__i  in  1  write enable
- AddrRd__i  in  ADDR_W  write address
- DataRd__i  in  DATA_W  write data
- Reserve__i  in  1  mark a destination pending (issue)
- AddrRes__i  in  ADDR_W  reserve address
- AddrR__i  in  NUM_RD*ADDR_W  read addresses; port k occupies bits [k*ADDR_W +: ADDR_W]
- DataR__o  out  NUM_RD*DATA_W  read data; port k occupies bits [k*DATA_W +: DATA_W]
- Pending__o  out  NUM_RD  port k's addressed register is pending

## Operation
- State machine has two states, CLEAR and RUN, plus a clear counter clr_cnt[ADDR_W-1:0].
- Reset:
  - Any cycle with reset__i=1 forces state=CLEAR, clr_cnt=0 and all pending bits to 0 at the next edge.
- CLEAR state, with reset__i=0, on each edge:
  - register[clr_cnt] <= 0.
  - clr_cnt increments by 1.
  - When clr_cnt==DEPTH-1, the state moves to RUN and clr_cnt wraps to 0.
- While in CLEAR:
  - RegWrite__i and Reserve__i are ignored.
  - DataR__o is all zeros and Pending__o is all zeros.
- RUN state:
  - RegWrite__i=1 writes DataRd__i into register[AddrRd__i] and clears pending[AddrRd__i].
  - Reserve__i=1 sets pending[AddrRes__i].
  - Reserve and write to the same address in the same cycle: the reserve wins and pending stays 1, because a newer producer has been issued.
  - Reset mid-operation: reset has priority over every other update. A reset asserted during CLEAR restarts the sweep at 0.
- ZERO_REG=1:
  - Writes and reserves to address 0 are dropped.
  - Reads of address 0 return 0 and Pending 0.
- Reads:
  - Each port is combinational: DataR port k = register[AddrR port k], subject to the zero and bypass rules.
  - Pending port k = pending[AddrR port k].
- Ready__o = (state==RUN).

## Timing
- Reset values:
  - Ready__o=0.
  - DataR__o=0 and Pending__o=0 (outputs are forced while in CLEAR).
  - Register array contents are undefined until the sweep passes them.
- Clear latency: Ready__o rises exactly DEPTH edges after the first edge with reset__i=0. That is 32 cycles at defaults.
- Write latency: data written at edge N is visible on a non-bypassed read from cycle N+1 onward.
- Pending set by a reserve at edge N is visible from cycle N+1.
- Read paths have zero-cycle latency; there are no registered outputs.

## Configuration
- REGFILE_BYPASS_EN defined:
  - In RUN, a read of the address being written this cycle returns DataRd__i in the same cycle.
  - Pending for that address reads 0, unless Reserve__i targets the same address in the same cycle.
  - This applies only when the address is non-zero, or when ZERO_REG=0.
- REGFILE_BYPASS_EN undefined:
  - The read returns the old register contents and the old pending bit until the next cycle.
  - This is the required mode for the split-phase pipeline, where writeback leads decode by one cycle.

## Test plan
- Clear sweep:
  - Stimulus: reset for 3 cycles, then release.
  - Required: Ready__o=0 for exactly 32 edges, then 1; all 32 addresses read 0x00000000.
- Write/read:
  - Stimulus: write 0xDEADBEEF to r5; read r5 on both ports in the next cycle.
  - Required: both ports return 0xDEADBEEF.
  - Stimulus: write 0x1234 to r0.
  - Required: r0 reads 0.
- Scoreboard:
  - Stimulus: reserve r7.
  - Required: Pending=1 from the next cycle.
  - Stimulus: write r7=0x55.
  - Required: Pending=0 next cycle, data=0x55.
  - Stimulus: reserve and write r7 in the same cycle.
  - Required: Pending stays 1.
- Bypass:
  - Stimulus: write r9=0xA5A5A5A5 while reading r9.
  - Required: 0xA5A5A5A5 in the same cycle with REGFILE_BYPASS_EN defined; the prior value without it.
- Reset mid-clear:
  - Stimulus: assert reset at sweep count 10 for 1 cycle.
  - Required: Ready__o rises 32 edges after that release, not 22; pending bits set before the reset read 0.
- Writes ignored in CLEAR:
  - Stimulus: write r3=0xFF during the sweep, after r3 has already been cleared.
  - Required: r3 reads 0 after Ready__o rises.
